// File: rtl/trig_pkg.sv
// Shared definitions for the central-trigger DI2C transmitter:
// FSM encoding, frame geometry and the CRC-16/KERMIT byte step.
package trig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CRC     = 3'd1,
    ST_PRE     = 3'd2,
    ST_START   = 3'd3,
    ST_SLOT    = 3'd4,
    ST_STOP_LO = 3'd5,
    ST_STOP_HI = 3'd6,
    ST_GAP     = 3'd7
  } state_t;

  localparam int FRAME_BYTES  = 8;
  localparam int SCL_PER_BYTE = 9;
  localparam int CRC_BYTES    = 6;

  localparam logic [15:0] CRC_POLY = 16'h8408;
  localparam logic [15:0] CRC_INIT = 16'h0000;

  // Reflected CRC-16/KERMIT update, data bits consumed LSB first.
  function automatic logic [15:0] crc16_kermit_step(input logic [15:0] crc_in,
                                                    input logic [7:0]  data);
    logic [15:0] c;
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = (c >> 1) ^ CRC_POLY;
      else      c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_kermit.sv
// Byte-serial CRC-16/KERMIT accumulator: one byte per enabled cycle, clr wins over en.
module crc16_kermit
  import trig_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data_byte,
  output logic [15:0] crc
);

  logic [15:0] crc_r;

  // CRC register: cleared at the start of every frame, updated once per fed byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc_r <= CRC_INIT;
    end else if (clr) begin
      crc_r <= CRC_INIT;
    end else if (en) begin
      crc_r <= crc16_kermit_step(crc_r, data_byte);
    end else begin
      crc_r <= crc_r;
    end
  end

  assign crc = crc_r;

endmodule

// File: rtl/trigger_tx.sv
// Central-trigger DI2C transmitter: waits on the sub-system busy line, then sends
// START, 8 bytes (id, type, serial, CRC) as 9-pulse slots, STOP and a bus-free gap.
module trigger_tx
  import trig_pkg::*;
#(
  parameter int QTR      = 25,
  parameter int GAP      = 200,
  parameter int BUSY_TMO = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trig_req,
  input  logic [7:0]  sub_system_id,
  input  logic [7:0]  trigger_type,
  input  logic [31:0] trigger_serial,
  output logic        ready,
  output logic        done,
  output logic        busy_timeout,
  input  logic        ro_sda,
  input  logic        ro_scl,
  output logic        ren_sda,
  output logic        ren_scl,
  output logic        de_sda,
  output logic        de_scl,
  output logic        di_sda,
  output logic        di_scl,
  input  logic        ro_busy,
  output logic        ren_busy,
  output logic        de_busy,
  output logic        di_busy
);

  localparam int CNT_MAX = (GAP > 4 * QTR) ? GAP : 4 * QTR;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int WAIT_W  = $clog2(BUSY_TMO + 1);

  localparam logic [CNT_W-1:0]  CRC_LAST  = CNT_W'(CRC_BYTES - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(2 * QTR - 1);
  localparam logic [CNT_W-1:0]  HALF_BIT  = CNT_W'(2 * QTR);
  localparam logic [CNT_W-1:0]  SLOT_LAST = CNT_W'(4 * QTR - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP - 1);
  localparam logic [3:0]        BIT_LAST  = 4'(SCL_PER_BYTE - 1);
  localparam logic [2:0]        BYTE_LAST = 3'(FRAME_BYTES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(BUSY_TMO);
  localparam logic [WAIT_W-1:0] WAIT_HIT  = WAIT_W'(BUSY_TMO - 1);

  state_t            state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic [3:0]        bit_r, bit_nxt_s;
  logic [2:0]        byte_r, byte_nxt_s;
  logic [7:0]        id_r, type_r;
  logic [31:0]       serial_r;
  logic [15:0]       crc_s;
  logic [7:0]        crc_byte_s, slot_byte_s;
  logic              busy_meta_r, busy_sync_r, busy_s;
  logic [WAIT_W-1:0] wait_r;
  logic              accept_s, waiting_s, crc_en_s;
  logic              sda_nxt_s, scl_nxt_s;
  logic              di_sda_r, di_scl_r, ready_r, done_r, busy_timeout_r;
  logic              unused_ro_s;

  function automatic logic [7:0] pick_byte(input logic [2:0]  sel,
                                           input logic [7:0]  id,
                                           input logic [7:0]  ty,
                                           input logic [31:0] ser,
                                           input logic [15:0] crc_v);
    case (sel)
      3'd0:    return id;
      3'd1:    return ty;
      3'd2:    return ser[31:24];
      3'd3:    return ser[23:16];
      3'd4:    return ser[15:8];
      3'd5:    return ser[7:0];
      3'd6:    return crc_v[15:8];
      3'd7:    return crc_v[7:0];
      default: return 8'h00;
    endcase
  endfunction

  assign busy_s    = busy_sync_r;
  assign accept_s  = (state_r == ST_IDLE) && trig_req && !busy_s;
  assign waiting_s = (state_r == ST_IDLE) && trig_req && busy_s;
  assign crc_en_s  = (state_r == ST_CRC);

  assign crc_byte_s  = pick_byte(cnt_r[2:0], id_r, type_r, serial_r, crc_s);
  assign slot_byte_s = pick_byte(byte_nxt_s, id_r, type_r, serial_r, crc_s);

  crc16_kermit u_crc (
    .clk       (clk),
    .reset     (reset),
    .clr       (accept_s),
    .en        (crc_en_s),
    .data_byte (crc_byte_s),
    .crc       (crc_s)
  );

  // Phase sequencing: one shared counter times every phase of the frame
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r + CNT_W'(1);
    bit_nxt_s   = bit_r;
    byte_nxt_s  = byte_r;
    case (state_r)
      ST_IDLE: begin
        cnt_nxt_s = '0;
        if (accept_s) state_nxt_s = ST_CRC;
        else          state_nxt_s = ST_IDLE;
      end
      ST_CRC: begin
        if (cnt_r == CRC_LAST) begin state_nxt_s = ST_PRE; cnt_nxt_s = '0; end
        else                   state_nxt_s = ST_CRC;
      end
      ST_PRE: begin
        if (cnt_r == HALF_LAST) begin state_nxt_s = ST_START; cnt_nxt_s = '0; end
        else                    state_nxt_s = ST_PRE;
      end
      ST_START: begin
        if (cnt_r == HALF_LAST) begin
          state_nxt_s = ST_SLOT;
          cnt_nxt_s   = '0;
          bit_nxt_s   = 4'd0;
          byte_nxt_s  = 3'd0;
        end else begin
          state_nxt_s = ST_START;
        end
      end
      ST_SLOT: begin
        if (cnt_r == SLOT_LAST) begin
          cnt_nxt_s = '0;
          if (bit_r == BIT_LAST) begin
            bit_nxt_s = 4'd0;
            if (byte_r == BYTE_LAST) state_nxt_s = ST_STOP_LO;
            else                     byte_nxt_s  = byte_r + 3'd1;
          end else begin
            bit_nxt_s = bit_r + 4'd1;
          end
        end else begin
          state_nxt_s = ST_SLOT;
        end
      end
      ST_STOP_LO: begin
        if (cnt_r == HALF_LAST) begin state_nxt_s = ST_STOP_HI; cnt_nxt_s = '0; end
        else                    state_nxt_s = ST_STOP_LO;
      end
      ST_STOP_HI: begin
        if (cnt_r == HALF_LAST) begin state_nxt_s = ST_GAP; cnt_nxt_s = '0; end
        else                    state_nxt_s = ST_STOP_HI;
      end
      ST_GAP: begin
        if (cnt_r == GAP_LAST) begin state_nxt_s = ST_IDLE; cnt_nxt_s = '0; end
        else                   state_nxt_s = ST_GAP;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Bus levels derived from the next phase so the registered pins line up with it
  always_comb begin
    sda_nxt_s = 1'b1;
    scl_nxt_s = 1'b1;
    case (state_nxt_s)
      ST_START: begin
        sda_nxt_s = 1'b0;
        scl_nxt_s = 1'b1;
      end
      ST_SLOT: begin
        scl_nxt_s = (cnt_nxt_s >= HALF_BIT);
        if (bit_nxt_s == BIT_LAST) sda_nxt_s = 1'b0;
        else                       sda_nxt_s = slot_byte_s[3'd7 - bit_nxt_s[2:0]];
      end
      ST_STOP_LO: begin
        sda_nxt_s = 1'b0;
        scl_nxt_s = 1'b0;
      end
      ST_STOP_HI: begin
        sda_nxt_s = 1'b0;
        scl_nxt_s = 1'b1;
      end
      default: begin
        sda_nxt_s = 1'b1;
        scl_nxt_s = 1'b1;
      end
    endcase
  end

  // FSM state, phase counters and registered bus/handshake outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      bit_r    <= 4'd0;
      byte_r   <= 3'd0;
      di_sda_r <= 1'b1;
      di_scl_r <= 1'b1;
      ready_r  <= 1'b1;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      bit_r    <= bit_nxt_s;
      byte_r   <= byte_nxt_s;
      di_sda_r <= sda_nxt_s;
      di_scl_r <= scl_nxt_s;
      ready_r  <= (state_nxt_s == ST_IDLE);
      done_r   <= (state_nxt_s == ST_GAP) && (cnt_nxt_s == GAP_LAST);
    end
  end

  // Field capture on accept; later input changes cannot reach the frame in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_r     <= 8'h00;
      type_r   <= 8'h00;
      serial_r <= 32'h0000_0000;
    end else if (accept_s) begin
      id_r     <= sub_system_id;
      type_r   <= trigger_type;
      serial_r <= trigger_serial;
    end else begin
      id_r     <= id_r;
      type_r   <= type_r;
      serial_r <= serial_r;
    end
  end

  // Two-flop synchronizer for the asynchronous busy line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_meta_r <= 1'b0;
      busy_sync_r <= 1'b0;
    end else begin
      busy_meta_r <= ro_busy;
      busy_sync_r <= busy_meta_r;
    end
  end

  // Busy wait counter (saturating) and sticky timeout flag cleared by the next accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_r         <= '0;
      busy_timeout_r <= 1'b0;
    end else begin
      if (waiting_s) begin
        if (wait_r != WAIT_MAX) wait_r <= wait_r + WAIT_W'(1);
        else                    wait_r <= wait_r;
      end else begin
        wait_r <= '0;
      end
      if (accept_s)                            busy_timeout_r <= 1'b0;
      else if (waiting_s && wait_r == WAIT_HIT) busy_timeout_r <= 1'b1;
      else                                     busy_timeout_r <= busy_timeout_r;
    end
  end

  assign unused_ro_s = ro_sda ^ ro_scl;

  assign di_sda       = di_sda_r;
  assign di_scl       = di_scl_r;
  assign ready        = ready_r;
  assign done         = done_r;
  assign busy_timeout = busy_timeout_r;
  assign ren_sda      = 1'b1;
  assign ren_scl      = 1'b1;
  assign de_sda       = 1'b1;
  assign de_scl       = 1'b1;
  assign ren_busy     = 1'b0;
  assign de_busy      = 1'b0;
  assign di_busy      = 1'b0;

endmodule

// File: tb/tb_trigger_tx.sv
// Self-checking bench for trigger_tx: vector table plus busy, back-to-back and
// mid-frame reset sequences; a bus monitor decodes frames against a scoreboard queue.
module tb_trigger_tx;

  localparam int QTR      = 4;
  localparam int GAP      = 20;
  localparam int BUSY_TMO = 50;
  localparam int N_FRAME  = 6 + 296 * QTR + GAP;

  logic        clk = 1'b0;
  logic        reset;
  logic        trig_req;
  logic [7:0]  sub_system_id, trigger_type;
  logic [31:0] trigger_serial;
  logic        ready, done, busy_timeout;
  logic        ro_sda, ro_scl, ro_busy;
  logic        ren_sda, ren_scl, de_sda, de_scl, di_sda, di_scl;
  logic        ren_busy, de_busy, di_busy;
  logic        c_clr, c_en;
  logic [7:0]  c_byte;
  logic [15:0] c_crc;

  trigger_tx #(.QTR(QTR), .GAP(GAP), .BUSY_TMO(BUSY_TMO)) dut (
    .clk(clk), .reset(reset), .trig_req(trig_req),
    .sub_system_id(sub_system_id), .trigger_type(trigger_type),
    .trigger_serial(trigger_serial), .ready(ready), .done(done),
    .busy_timeout(busy_timeout), .ro_sda(ro_sda), .ro_scl(ro_scl),
    .ren_sda(ren_sda), .ren_scl(ren_scl), .de_sda(de_sda), .de_scl(de_scl),
    .di_sda(di_sda), .di_scl(di_scl), .ro_busy(ro_busy),
    .ren_busy(ren_busy), .de_busy(de_busy), .di_busy(di_busy)
  );

  crc16_kermit crc_dut (
    .clk(clk), .reset(reset), .clr(c_clr), .en(c_en), .data_byte(c_byte), .crc(c_crc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference CRC: MSB-first 0x1021 on bit-reversed bytes, output bit-reversed
  function automatic logic [15:0] model_crc(input logic [47:0] msg);
    logic [15:0] r;
    logic [15:0] o;
    logic [7:0]  by;
    logic        fb;
    r = 16'h0000;
    for (int b = 0; b < 6; b++) begin
      by = msg[47 - 8 * b -: 8];
      for (int i = 0; i < 8; i++) begin
        fb = r[15] ^ by[i];
        r  = {r[14:0], 1'b0};
        if (fb) r = r ^ 16'h1021;
      end
    end
    for (int i = 0; i < 16; i++) o[i] = r[15 - i];
    return o;
  endfunction

  function automatic logic [63:0] model_frame(input logic [7:0] id, input logic [7:0] ty,
                                              input logic [31:0] ser);
    return {id, ty, ser, model_crc({id, ty, ser})};
  endfunction

  // ---------------- bus monitor ----------------
  logic        p_sda = 1'b1, p_scl = 1'b1, p_ready = 1'b1, p_done = 1'b0;
  bit          in_fr = 1'b0;
  int          nrise = 0;
  logic [71:0] bits;
  int          acc_cyc = 0, start_cyc = 0, stop_cyc = 0;
  int          n_start = 0, n_stop = 0, n_done = 0;

  initial begin : monitor
    logic [63:0] got, expf;
    logic [7:0]  dmy;
    forever begin
      @(negedge clk);
      if (!reset) begin
        in_fr = 1'b0; p_sda = 1'b1; p_scl = 1'b1; p_ready = 1'b1; p_done = 1'b0;
      end else begin
        if (p_ready && !ready) acc_cyc = cyc;
        if (p_scl && di_scl && p_sda && !di_sda) begin
          check("no_restart", 64'(in_fr), 64'd0);
          check("start_timing", 64'(cyc - acc_cyc), 64'(6 + 2 * QTR));
          in_fr = 1'b1; nrise = 0; bits = '0; start_cyc = cyc; n_start++;
        end else if (p_scl && di_scl && !p_sda && di_sda) begin
          stop_cyc = cyc; n_stop++;
          check("stop_in_frame", 64'(in_fr), 64'd1);
          if (in_fr) begin
            check("data_pulses", 64'(nrise - 1), 64'd72);
            check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
              expf = exp_q.pop_front();
              for (int b = 0; b < 8; b++) begin
                for (int j = 0; j < 8; j++) got[63 - 8 * b - j] = bits[71 - 9 * b - j];
                dmy[b] = bits[71 - 9 * b - 8];
              end
              check("frame_bytes", got, expf);
              check("dummy_bits", 64'(dmy), 64'd0);
            end
          end
          in_fr = 1'b0;
        end
        if (!p_scl && di_scl && in_fr) begin
          if (nrise < 72) bits[71 - nrise] = di_sda;
          nrise++;
        end
        if (done) begin
          n_done++;
          check("done_latency", 64'(cyc - acc_cyc), 64'(N_FRAME - 1));
        end
        if (p_done) check("done_width", 64'(done), 64'd0);
        p_sda = di_sda; p_scl = di_scl; p_ready = ready; p_done = done;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_accept();
    int t = 0;
    while (ready === 1'b1 && t < 200) begin @(negedge clk); t++; end
    check("accept_seen", 64'(ready), 64'd0);
  endtask

  task automatic wait_done();
    int t = 0;
    while (done !== 1'b1 && t < N_FRAME + 100) begin @(negedge clk); t++; end
    check("done_seen", 64'(done), 64'd1);
  endtask

  task automatic send_frame(input logic [7:0] id, input logic [7:0] ty,
                            input logic [31:0] ser, input bit busy_mid,
                            input logic [63:0] expf);
    @(negedge clk);
    sub_system_id = id; trigger_type = ty; trigger_serial = ser; trig_req = 1'b1;
    exp_q.push_back(expf);
    wait_accept();
    trig_req = 1'b0;
    sub_system_id = ~id; trigger_type = ~ty; trigger_serial = ~ser;
    check("timeout_low", 64'(busy_timeout), 64'd0);
    if (busy_mid) begin
      ro_busy = 1'b1;
      repeat (200) @(negedge clk);
      ro_busy = 1'b0;
    end
    wait_done();
    repeat (2) @(negedge clk);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
  endtask

  typedef struct {
    logic [7:0]  id;
    logic [7:0]  ty;
    logic [31:0] serial;
    bit          busy_mid;
    logic [63:0] exp_frame;
  } vec_t;

  vec_t vecs[6];

  initial begin : driver
    string s;
    int    t, d, stop_a, n_start0, n_done0;
    s = "123456789";
    reset = 1'b0; trig_req = 1'b0; ro_busy = 1'b0; ro_sda = 1'b0; ro_scl = 1'b0;
    sub_system_id = 8'h00; trigger_type = 8'h00; trigger_serial = 32'h0;
    c_clr = 1'b0; c_en = 1'b0; c_byte = 8'h00;

    vecs[0] = '{8'h00, 8'h00, 32'h0000_0000, 1'b0, 64'h0};
    vecs[1] = '{8'hA5, 8'h3C, 32'h1234_5678, 1'b0, 64'h0};
    vecs[2] = '{8'hFF, 8'hFF, 32'hFFFF_FFFF, 1'b1, 64'h0};
    vecs[3] = '{8'h01, 8'h80, 32'h8000_0001, 1'b0, 64'h0};
    vecs[4] = '{8'($urandom), 8'($urandom), 32'($urandom), 1'b1, 64'h0};
    vecs[5] = '{8'($urandom), 8'($urandom), 32'($urandom), 1'b0, 64'h0};
    foreach (vecs[i]) vecs[i].exp_frame = model_frame(vecs[i].id, vecs[i].ty, vecs[i].serial);

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_timeout", 64'(busy_timeout), 64'd0);
    check("rst_bus", 64'({di_sda, di_scl}), 64'h3);
    check("const_en", 64'({ren_sda, ren_scl, de_sda, de_scl}), 64'hF);
    check("const_busy", 64'({ren_busy, de_busy, di_busy}), 64'h0);
    check("rst_crc", 64'(c_crc), 64'h0);
    reset = 1'b1;

    // standalone CRC unit
    @(negedge clk); c_clr = 1'b1;
    @(negedge clk); c_clr = 1'b0; c_en = 1'b1;
    for (int i = 0; i < 9; i++) begin c_byte = s[i]; @(negedge clk); end
    c_en = 1'b0;
    check("crc_123456789", 64'(c_crc), 64'h2189);
    c_clr = 1'b1;
    @(negedge clk); c_clr = 1'b0; c_en = 1'b1; c_byte = 8'h00;
    repeat (6) @(negedge clk);
    c_en = 1'b0;
    check("crc_zeros", 64'(c_crc), 64'h0000);

    // table-driven frames
    for (int i = 0; i < 6; i++)
      send_frame(vecs[i].id, vecs[i].ty, vecs[i].serial, vecs[i].busy_mid, vecs[i].exp_frame);

    // busy wait and timeout
    @(negedge clk); ro_busy = 1'b1;
    repeat (4) @(negedge clk);
    n_start0 = n_start;
    sub_system_id = 8'h5A; trigger_type = 8'hC3; trigger_serial = 32'hDEAD_BEEF;
    trig_req = 1'b1;
    exp_q.push_back(model_frame(8'h5A, 8'hC3, 32'hDEAD_BEEF));
    repeat (45) @(negedge clk);
    check("tmo_early", 64'(busy_timeout), 64'd0);
    check("busy_ready", 64'(ready), 64'd1);
    repeat (10) @(negedge clk);
    check("tmo_set", 64'(busy_timeout), 64'd1);
    check("busy_no_start", 64'(n_start - n_start0), 64'd0);
    ro_busy = 1'b0; d = cyc;
    wait_accept();
    trig_req = 1'b0;
    check("tmo_cleared", 64'(busy_timeout), 64'd0);
    wait_done();
    check("busy_start_lat", 64'(start_cyc - d), 64'(6 + 2 * QTR + 3));
    repeat (2) @(negedge clk);

    // back-to-back with trig_req held; second fields loaded after first accept
    sub_system_id = 8'h11; trigger_type = 8'h22; trigger_serial = 32'h3344_5566;
    trig_req = 1'b1;
    exp_q.push_back(model_frame(8'h11, 8'h22, 32'h3344_5566));
    wait_accept();
    sub_system_id = 8'h99; trigger_type = 8'h88; trigger_serial = 32'h7766_5544;
    exp_q.push_back(model_frame(8'h99, 8'h88, 32'h7766_5544));
    wait_done();
    stop_a = stop_cyc;
    @(negedge clk);
    check("b2b_ready_1", 64'(ready), 64'd1);
    @(negedge clk);
    check("b2b_accept", 64'(ready), 64'd0);
    trig_req = 1'b0;
    wait_done();
    check("b2b_idle_gap", 64'((start_cyc - stop_a) >= GAP + 2 * QTR), 64'd1);
    repeat (2) @(negedge clk);
    check("b2b_drained", 64'(exp_q.size()), 64'd0);

    // async reset during slot 30
    sub_system_id = 8'h42; trigger_type = 8'h24; trigger_serial = 32'h0BAD_F00D;
    trig_req = 1'b1;
    exp_q.push_back(model_frame(8'h42, 8'h24, 32'h0BAD_F00D));
    wait_accept();
    trig_req = 1'b0;
    repeat (6 + 2 * QTR + 4) @(negedge clk);
    t = 0;
    while (nrise < 31 && t < N_FRAME) begin @(negedge clk); t++; end
    check("reached_slot30", 64'(nrise >= 31), 64'd1);
    n_done0 = n_done;
    #2 reset = 1'b0;
    #1;
    check("rst_mid_bus", 64'({di_sda, di_scl}), 64'h3);
    check("rst_mid_ready", 64'(ready), 64'd1);
    void'(exp_q.pop_back());
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (N_FRAME) @(negedge clk);
    check("rst_no_done", 64'(n_done - n_done0), 64'd0);
    send_frame(8'hC0, 8'hDE, 32'hCAFE_1234, 1'b0, model_frame(8'hC0, 8'hDE, 32'hCAFE_1234));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
